// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//  Bundles the two requester ports and the single-port RAM bus seen by ram_arbiter.
//  master modport: the requesters plus the RAM (the environment around the arbiter).
//  slave modport:  the arbiter itself.
//  Signals:
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1  request side, held until ack
//   ack0/ack1, err0/err1, rdata0/rdata1              completion side, valid with ack
//   busy                                             arbiter not idle
//   ram_we, ram_addr, ram_wdata, ram_rdata           RAM MemWrite / A / WriteData / ReadData
interface ram_arbiter_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   logic          req0;
   logic          req1;
   logic          we0;
   logic          we1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic          ack0;
   logic          ack1;
   logic          err0;
   logic          err1;
   logic [DW-1:0] rdata0;
   logic [DW-1:0] rdata1;
   logic          busy;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
      input  ack0, ack1, err0, err1, rdata0, rdata1, busy, ram_we, ram_addr, ram_wdata
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
      output ack0, ack1, err0, err1, rdata0, rdata1, busy, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
//  Two-port round-robin arbiter/sequencer in front of a single-port data RAM.
//  Port 0 is the CPU load/store unit, port 1 a secondary master. One transaction
//  at a time; only word-aligned addresses inside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)
//  reach the RAM, anything else completes immediately with err.
//  Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active low
//   bus  ram_arbiter_if.slave: requester ports 0/1, busy, and the RAM bus
//  Every output is a flop; outputs are computed from the next-state decision.
module ram_arbiter #(
   parameter int            DW          = 32,
   parameter int            AW          = 32,
   parameter logic [AW-1:0] BASE_ADDR   = 'h1000,
   parameter int            DEPTH_WORDS = 64,
   parameter int            RD_LAT      = 1
) (
   input logic          clk,
   input logic          rst,
   ram_arbiter_if.slave bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] WAIT   = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam int          CW           = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   // One extra bit so the window end cannot wrap for windows touching the top of the address space.
   localparam logic [AW:0] WINDOW_BYTES = (AW+1)'(4 * DEPTH_WORDS);

   logic [1:0]    state;
   logic [1:0]    state_next;
   logic          last_grant;
   logic          gnt_port;
   logic          lat_we;
   logic [CW-1:0] cnt;

   logic          grant_valid;
   logic          grant_port;
   logic          sel_we;
   logic          sel_ok;
   logic [AW-1:0] sel_addr;
   logic [AW-1:0] sel_offset;
   logic [DW-1:0] sel_wdata;
   logic          enter_done;
   logic          done_port;

   // Round robin: with both ports requesting, the one not served last wins.
   assign grant_valid = (state == IDLE) && (bus.req0 || bus.req1);
   assign grant_port  = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;

   assign sel_we     = grant_port ? bus.we1    : bus.we0;
   assign sel_addr   = grant_port ? bus.addr1  : bus.addr0;
   assign sel_wdata  = grant_port ? bus.wdata1 : bus.wdata0;
   assign sel_offset = sel_addr - BASE_ADDR;
   assign sel_ok     = (sel_addr[1:0] == 2'b00) && (sel_addr >= BASE_ADDR) &&
                       ({1'b0, sel_offset} < WINDOW_BYTES);

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               state_next = sel_ok ? ACCESS : DONE;
            end
         end
         ACCESS:  state_next = lat_we ? DONE : WAIT;
         WAIT: begin
            if (cnt == '0) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // DONE is only reached directly from IDLE on a decode error, so that path is the err path.
   assign enter_done = (state_next == DONE) && (state != DONE);
   assign done_port  = (state == IDLE) ? grant_port : gnt_port;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         gnt_port      <= 1'b0;
         lat_we        <= 1'b0;
         cnt           <= '0;
         bus.busy      <= 1'b0;
         bus.ack0      <= 1'b0;
         bus.ack1      <= 1'b0;
         bus.err0      <= 1'b0;
         bus.err1      <= 1'b0;
         bus.rdata0    <= '0;
         bus.rdata1    <= '0;
         bus.ram_we    <= 1'b0;
         bus.ram_addr  <= '0;
         bus.ram_wdata <= '0;
      end else begin
         state    <= state_next;
         bus.busy <= (state_next != IDLE);
         bus.ack0 <= enter_done && !done_port;
         bus.ack1 <= enter_done && done_port;
         bus.err0 <= enter_done && (state == IDLE) && !done_port;
         bus.err1 <= enter_done && (state == IDLE) && done_port;
         // The write strobe can only rise together with the move into ACCESS.
         bus.ram_we <= grant_valid && sel_ok && sel_we;

         if (grant_valid) begin
            last_grant <= grant_port;
            gnt_port   <= grant_port;
            lat_we     <= sel_we;
         end

         // RAM address/data stay put after ACCESS so a multi-cycle read sees a stable address.
         if (grant_valid && sel_ok) begin
            bus.ram_addr  <= sel_offset;
            bus.ram_wdata <= sel_wdata;
         end

         if (state == ACCESS) begin
            cnt <= CW'(RD_LAT - 1);
         end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
         end

         if ((state == WAIT) && (state_next == DONE)) begin
            if (gnt_port) begin
               bus.rdata1 <= bus.ram_rdata;
            end else begin
               bus.rdata0 <= bus.ram_rdata;
            end
         end else if ((state == IDLE) && enter_done && !sel_we) begin
            if (grant_port) begin
               bus.rdata1 <= '0;
            end else begin
               bus.rdata0 <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//  Drives both requester ports of ram_arbiter with directed and random transactions,
//  hosts a behavioural RAM on the RAM bus, and predicts service order, completion
//  cycle, err and read data from a transaction-level model (word array + last grant).
module tb_ram_arbiter;

   localparam int          DW     = 32;
   localparam int          AW     = 32;
   localparam logic [31:0] BASE   = 32'h1000;
   localparam int          DEPTH  = 64;
   localparam int          RD_LAT = 1;
   localparam int          CYCLES = 2 * (RD_LAT + 2) + 4;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   logic clk = 1'b0;
   logic rst;

   ram_arbiter_if #(.DW(DW), .AW(AW)) bus ();

   ram_arbiter #(
      .DW(DW), .AW(AW), .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int          num_checks = 0;
   int          num_errors = 0;
   int          last_grant_m;
   logic [31:0] ref_mem [0:DEPTH-1];
   logic [31:0] exp_rdata_m [0:1];
   logic        exp_err_m [0:1];
   logic [31:0] ram_mem [0:DEPTH-1];

   function automatic logic [31:0] initWord(input int i);
      return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   // Behavioural single-port RAM with one cycle of read latency; reloads its pattern on reset.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) ram_mem[i] <= initWord(i);
         bus.ram_rdata <= '0;
      end else begin
         if (bus.ram_we) ram_mem[bus.ram_addr[7:2]] <= bus.ram_wdata;
         bus.ram_rdata <= ram_mem[bus.ram_addr[7:2]];
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit addrInWindow(input logic [31:0] a);
      longint unsigned al;
      al = longint'(a);
      return (a[1:0] == 2'b00) && (al >= longint'(BASE)) && (al < longint'(BASE) + 4 * DEPTH);
   endfunction

   function automatic int wordIndex(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   // Cycles from the sampling edge until the ack cycle, counting the ack cycle.
   function automatic int txnLatency(input txn_t t);
      if (!addrInWindow(t.addr)) return 1;
      if (t.we) return 2;
      return 2 + RD_LAT;
   endfunction

   function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      txn_t t;
      t.we = we;
      t.addr = addr;
      t.wdata = wdata;
      return t;
   endfunction

   function automatic txn_t randTxn();
      txn_t t;
      int   sel;
      t.we    = 1'($urandom_range(0, 1));
      t.wdata = $urandom;
      sel     = $urandom_range(0, 9);
      case (sel)
         0, 1, 2, 3, 4: t.addr = BASE + 32'(4 * $urandom_range(0, 7));
         5:       t.addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
         6:       t.addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
         7:       t.addr = 32'($urandom_range(0, 32'hFFF));
         8:       t.addr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 4095));
         default: t.addr = $urandom_range(0, 1) ? BASE + 32'(4 * DEPTH - 4) : BASE + 32'(4 * DEPTH);
      endcase
      return t;
   endfunction

   function automatic void resetModel();
      last_grant_m = 1;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = initWord(i);
      exp_rdata_m[0] = '0;
      exp_rdata_m[1] = '0;
      exp_err_m[0] = 1'b0;
      exp_err_m[1] = 1'b0;
   endfunction

   // Raise the selected requests together on an idle arbiter and watch one full round.
   task automatic applyStimulus(input bit r0, input bit r1, input txn_t t0, input txn_t t1);
      txn_t t [0:1];
      int   order [0:1];
      int   exp_ack [0:1];
      int   exp_acc [0:1];
      int   got_ack [0:1];
      int   ack_cnt [0:1];
      int   n_srv, s_edge, p, we_cnt, exp_we_cnt;
      t[0] = t0;
      t[1] = t1;
      order[0] = 0;
      order[1] = 1;
      for (int q = 0; q < 2; q++) begin
         exp_ack[q] = -1;
         exp_acc[q] = -1;
         got_ack[q] = -1;
         ack_cnt[q] = 0;
      end
      we_cnt = 0;
      exp_we_cnt = 0;
      n_srv = 0;
      if (r0 && r1) begin
         order[0] = (last_grant_m == 0) ? 1 : 0;
         order[1] = 1 - order[0];
         n_srv = 2;
      end else if (r0 || r1) begin
         order[0] = r0 ? 0 : 1;
         n_srv = 1;
      end

      s_edge = 1;
      for (int s = 0; s < n_srv; s++) begin
         p = order[s];
         exp_acc[p] = s_edge;
         exp_ack[p] = s_edge + txnLatency(t[p]) - 1;
         last_grant_m = p;
         if (!addrInWindow(t[p].addr)) begin
            exp_err_m[p] = 1'b1;
            if (!t[p].we) exp_rdata_m[p] = '0;
         end else begin
            exp_err_m[p] = 1'b0;
            if (t[p].we) begin
               ref_mem[wordIndex(t[p].addr)] = t[p].wdata;
               exp_we_cnt++;
            end else begin
               exp_rdata_m[p] = ref_mem[wordIndex(t[p].addr)];
            end
         end
         // Ack cycle, then one cycle back in IDLE, then the next sampling edge.
         s_edge = exp_ack[p] + 2;
      end

      bus.req0 = r0; bus.we0 = t0.we; bus.addr0 = t0.addr; bus.wdata0 = t0.wdata;
      bus.req1 = r1; bus.we1 = t1.we; bus.addr1 = t1.addr; bus.wdata1 = t1.wdata;

      for (int k = 1; k <= CYCLES; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) checkOutput("busy_active", bus.busy, 64'(r0 || r1));
         if (bus.ack0) begin
            ack_cnt[0]++;
            if (got_ack[0] < 0) begin
               got_ack[0] = k;
               checkOutput("err0", bus.err0, exp_err_m[0]);
               checkOutput("rdata0_ack", bus.rdata0, exp_rdata_m[0]);
            end
            bus.req0 = 1'b0;
         end
         if (bus.ack1) begin
            ack_cnt[1]++;
            if (got_ack[1] < 0) begin
               got_ack[1] = k;
               checkOutput("err1", bus.err1, exp_err_m[1]);
               checkOutput("rdata1_ack", bus.rdata1, exp_rdata_m[1]);
            end
            bus.req1 = 1'b0;
         end
         if (bus.ram_we) we_cnt++;
         for (int q = 0; q < 2; q++) begin
            if ((k == exp_acc[q]) && addrInWindow(t[q].addr)) begin
               checkOutput("ram_addr", bus.ram_addr, t[q].addr - BASE);
               checkOutput("ram_we_access", bus.ram_we, t[q].we);
               if (t[q].we) checkOutput("ram_wdata", bus.ram_wdata, t[q].wdata);
            end
         end
      end

      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      checkOutput("ack_cycle0", 64'(got_ack[0]), 64'(exp_ack[0]));
      checkOutput("ack_cycle1", 64'(got_ack[1]), 64'(exp_ack[1]));
      checkOutput("ack_count0", 64'(ack_cnt[0]), 64'(r0));
      checkOutput("ack_count1", 64'(ack_cnt[1]), 64'(r1));
      checkOutput("ram_we_cycles", 64'(we_cnt), 64'(exp_we_cnt));
      checkOutput("busy_idle", bus.busy, 64'(0));
      checkOutput("rdata0_hold", bus.rdata0, exp_rdata_m[0]);
      checkOutput("rdata1_hold", bus.rdata1, exp_rdata_m[1]);
   endtask

   // Start a port 0 write, pull reset during its ACCESS cycle, and expect a silent abort.
   task automatic resetMidWrite();
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h1010; bus.wdata0 = 32'hDEAD_BEEF;
      bus.req1 = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst_pre_ram_we", bus.ram_we, 64'(1));
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_ram_we", bus.ram_we, 64'(0));
      checkOutput("rst_busy", bus.busy, 64'(0));
      checkOutput("rst_ack0", bus.ack0, 64'(0));
      checkOutput("rst_rdata0", bus.rdata0, 64'(0));
      bus.req0 = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         checkOutput("rst_no_ack", {bus.ack0, bus.ack1}, 64'(0));
      end
      rst = 1'b1;
      resetModel();
   endtask

   initial begin
      bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
      rst = 1'b1;
      resetModel();
      #2 rst = 1'b0;
      #3;
      checkOutput("reset_ack0", bus.ack0, 64'(0));
      checkOutput("reset_ack1", bus.ack1, 64'(0));
      checkOutput("reset_err0", bus.err0, 64'(0));
      checkOutput("reset_err1", bus.err1, 64'(0));
      checkOutput("reset_busy", bus.busy, 64'(0));
      checkOutput("reset_ram_we", bus.ram_we, 64'(0));
      checkOutput("reset_rdata0", bus.rdata0, 64'(0));
      checkOutput("reset_rdata1", bus.rdata1, 64'(0));
      checkOutput("reset_ram_addr", bus.ram_addr, 64'(0));
      checkOutput("reset_ram_wdata", bus.ram_wdata, 64'(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      $display("[TB] directed transactions");
      applyStimulus(1, 0, mk(1'b1, 32'h1000, 32'h13FF), randTxn());
      applyStimulus(0, 1, randTxn(), mk(1'b0, 32'h1000, 32'h0));
      applyStimulus(1, 1, mk(1'b1, 32'h1004, 32'h100), mk(1'b0, 32'h1004, 32'h0));
      applyStimulus(1, 1, mk(1'b0, 32'h1000, 32'h0), mk(1'b1, 32'h1008, 32'h5A5A));
      applyStimulus(1, 0, mk(1'b0, 32'h1000, 32'h0), randTxn());
      applyStimulus(1, 0, mk(1'b0, 32'h2000, 32'h0), randTxn());
      applyStimulus(1, 0, mk(1'b0, 32'h1004, 32'h0), randTxn());
      applyStimulus(1, 0, mk(1'b0, 32'h1002, 32'h0), randTxn());
      applyStimulus(1, 0, mk(1'b0, 32'h10FC, 32'h0), randTxn());
      applyStimulus(1, 0, mk(1'b0, 32'h1100, 32'h0), randTxn());

      $display("[TB] reset during write access");
      resetMidWrite();
      applyStimulus(1, 1, mk(1'b0, 32'h1010, 32'h0), mk(1'b1, 32'h1010, 32'h7777));
      applyStimulus(0, 1, randTxn(), mk(1'b0, 32'h1010, 32'h0));

      $display("[TB] random transactions");
      for (int i = 0; i < 80; i++) begin
         int pat;
         pat = $urandom_range(0, 2);
         applyStimulus(pat != 1, pat != 0, randTxn(), randTxn());
      end

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not reach its end, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
